data_memory: RTL and testbench

Data-side memory responder for `core`: services the core's single-cycle store/load port (`memory_write_enable`, `memory_address`, `memory_write_data`, `memory_read_data`) with a word RAM plus a small MMIO window. The window holds a byte console FIFO drained over a valid/ready stream, a status register, and a free-running cycle counter. It sits beside `core` in the top level and is the far end of the core's data memory interface.

---
 rtl/data_memory.sv | 206 ++++++++++++++++++++
 tb/tb_data_memory.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// data_memory
//
// Data-side responder for the core's single-cycle load/store port. Backs a
// word RAM at the bottom of the address space and a small MMIO window holding
// a byte console FIFO, a FIFO status register and a free-running cycle counter.
//
// Ports
//   clk                  clock, all state updates on the rising edge
//   rst                  synchronous active-high reset
//   memory_write_enable  store strobe from the core
//   memory_address       byte address from the core (full-width decode)
//   memory_write_data    store data from the core
//   memory_read_data     combinational read data (state before the edge)
//   console_valid        console FIFO holds at least one byte
//   console_data         byte at the FIFO read pointer
//   console_ready        sink takes the head byte this cycle
//   access_fault         sticky flag: unmapped or misaligned access observed
//
// Map
//   0x0000_0000 .. DEPTH_WORDS*4-1  RAM (word access only)
//   0x8000_0000                     CONSOLE_DATA (write pushes byte, reads 0)
//   0x8000_0004                     STATUS (bit0 full, bit1 empty,
//                                   bit2 overflow, bits[15:8] count)
//   0x8000_0008                     CYCLE (read-only, writes ignored)
module data_memory #(
  parameter int XLEN               = 32,
  parameter int DEPTH_WORDS        = 1024,
  parameter int CONSOLE_FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            memory_write_enable,
  input  logic [XLEN-1:0] memory_address,
  input  logic [XLEN-1:0] memory_write_data,
  output logic [XLEN-1:0] memory_read_data,
  output logic            console_valid,
  output logic [7:0]      console_data,
  input  logic            console_ready,
  output logic            access_fault
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(CONSOLE_FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [XLEN-1:0] CONSOLE_ADDR = XLEN'(32'h8000_0000);
  localparam logic [XLEN-1:0] STATUS_ADDR  = XLEN'(32'h8000_0004);
  localparam logic [XLEN-1:0] CYCLE_ADDR   = XLEN'(32'h8000_0008);
  localparam logic [CW-1:0]   FULL_COUNT   = CW'(CONSOLE_FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic          aligned;
  logic          is_ram;
  logic          is_console;
  logic          is_status;
  logic          is_cycle;
  logic          is_mapped;
  logic          bad_access;
  logic [AW-1:0] word_index;

  assign aligned    = (memory_address[1:0] == 2'b00);
  assign is_ram     = (memory_address[XLEN-1:AW+2] == '0);
  assign is_console = (memory_address == CONSOLE_ADDR);
  assign is_status  = (memory_address == STATUS_ADDR);
  assign is_cycle   = (memory_address == CYCLE_ADDR);
  assign is_mapped  = is_ram | is_console | is_status | is_cycle;
  assign bad_access = !is_mapped || !aligned;
  assign word_index = memory_address[AW+1:2];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] ram_reg [DEPTH_WORDS];
  logic [7:0]      fifo_reg [CONSOLE_FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            overflow_reg, overflow_next;
  logic            fault_reg, fault_next;
  logic [XLEN-1:0] cycle_reg;

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic push_accept;
  logic status_write;
  logic ram_write;

  assign fifo_full    = (count_reg == FULL_COUNT);
  assign fifo_empty   = (count_reg == '0);
  assign push         = memory_write_enable && is_console;
  assign pop          = !fifo_empty && console_ready;
  // A pop in the same cycle frees the slot the push needs, so a full FIFO
  // still takes the byte when the sink drains one.
  assign push_accept  = push && (!fifo_full || pop);
  assign status_write = memory_write_enable && is_status;
  assign ram_write    = memory_write_enable && is_ram && aligned;

  always_comb begin
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    fault_next    = fault_reg;

    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    if (push_accept) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    case ({push_accept, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    if (push && !push_accept) begin
      overflow_next = 1'b1;
    end else if (status_write) begin
      overflow_next = 1'b0;
    end

    // The core parks the bus at address 0 when idle; address 0 is a valid
    // RAM word, so it can never look like a fault here. A read shares the
    // address of any write in the same cycle, so the write alone decides.
    if (bad_access && (memory_write_enable || memory_address != '0)) begin
      fault_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      fault_reg    <= 1'b0;
      cycle_reg    <= '0;
    end else begin
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      fault_reg    <= fault_next;
      cycle_reg    <= cycle_reg + 1'b1;
    end
  end

  // One register per FIFO slot; only the slot at the write pointer loads.
  generate
    for (genvar gi = 0; gi < CONSOLE_FIFO_DEPTH; gi++) begin : g_fifo_slot
      always_ff @(posedge clk) begin
        if (rst) begin
          fifo_reg[gi] <= 8'h00;
        end else if (push_accept && (wr_ptr_reg == PW'(gi))) begin
          fifo_reg[gi] <= memory_write_data[7:0];
        end
      end
    end
  endgenerate

  // RAM has no reset; a store that coincides with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && ram_write) begin
      ram_reg[word_index] <= memory_write_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] status_word;

  always_comb begin
    status_word         = '0;
    status_word[0]      = fifo_full;
    status_word[1]      = fifo_empty;
    status_word[2]      = overflow_reg;
    status_word[8 +: CW] = count_reg;
  end

  always_comb begin
    memory_read_data = '0;
    if (aligned) begin
      if (is_ram) begin
        memory_read_data = ram_reg[word_index];
      end else if (is_status) begin
        memory_read_data = status_word;
      end else if (is_cycle) begin
        memory_read_data = cycle_reg;
      end
    end
  end

  assign console_valid = !fifo_empty;
  assign console_data  = fifo_reg[rd_ptr_reg];
  assign access_fault  = fault_reg;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios followed by random
// traffic, all compared against a queue/array reference model of the memory
// map, console FIFO, status flags, fault flag and cycle counter.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        memory_write_enable;
  logic [31:0] memory_address;
  logic [31:0] memory_write_data;
  logic [31:0] memory_read_data;
  logic        console_valid;
  logic [7:0]  console_data;
  logic        console_ready;
  logic        access_fault;

  data_memory dut (
    .clk                 (clk),
    .rst                 (rst),
    .memory_write_enable (memory_write_enable),
    .memory_address      (memory_address),
    .memory_write_data   (memory_write_data),
    .memory_read_data    (memory_read_data),
    .console_valid       (console_valid),
    .console_data        (console_data),
    .console_ready       (console_ready),
    .access_fault        (access_fault)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model
  logic [31:0] ram_m [1024];
  bit          ram_v [1024];
  logic [7:0]  q [$];
  bit          ovf_m;
  bit          fault_m;
  logic [31:0] cyc_m;

  function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
    v = 32'h0;
    if (a[1:0] != 2'b00) return 1'b1;
    if (a < 32'h1000) begin
      v = ram_m[a[11:2]];
      return ram_v[a[11:2]];
    end
    if (a == 32'h8000_0004) begin
      v = {16'h0, 8'(q.size()), 5'b0, ovf_m, q.size() == 0, q.size() == 4};
    end else if (a == 32'h8000_0008) begin
      v = cyc_m;
    end
    return 1'b1;
  endfunction

  function automatic bit model_bad(input logic [31:0] a);
    bit mapped;
    mapped = (a < 32'h1000) || a == 32'h8000_0000 || a == 32'h8000_0004 || a == 32'h8000_0008;
    return !mapped || a[1:0] != 2'b00;
  endfunction

  task automatic model_edge(input bit r, input bit w, input logic [31:0] a,
                            input logic [31:0] d, input bit rdy);
    bit popped;
    if (r) begin
      q.delete();
      ovf_m   = 1'b0;
      fault_m = 1'b0;
      cyc_m   = 32'h0;
      return;
    end
    if (model_bad(a) && (w || a != 0)) fault_m = 1'b1;
    if (w && a[1:0] == 2'b00 && a < 32'h1000) begin
      ram_m[a[11:2]] = d;
      ram_v[a[11:2]] = 1'b1;
    end
    popped = (q.size() != 0) && rdy;
    if (popped) void'(q.pop_front());
    if (w && a == 32'h8000_0000) begin
      // the pop already happened above, so a full FIFO with a pop has room
      if (q.size() < 4) q.push_back(d[7:0]);
      else ovf_m = 1'b1;
    end
    if (w && a == 32'h8000_0004) ovf_m = 1'b0;
    cyc_m = cyc_m + 1;
  endtask

  // One bus cycle: drive, compare outputs against the pre-edge model, clock.
  task automatic step(input bit r, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input bit rdy, output logic [31:0] rd);
    logic [31:0] ev;
    rst                 = r;
    memory_write_enable = w;
    memory_address      = a;
    memory_write_data   = d;
    console_ready       = rdy;
    #3;
    rd = memory_read_data;
    if (model_read(a, ev)) check("rdata", rd, ev);
    check("console_valid", {31'b0, console_valid}, {31'b0, q.size() != 0});
    if (q.size() != 0) check("console_data", {24'b0, console_data}, {24'b0, q[0]});
    check("access_fault", {31'b0, access_fault}, {31'b0, fault_m});
    $display("[TB] rst=%0d we=%0d addr=%08h wdata=%08h rdy=%0d rdata=%08h cv=%0d cd=%02h af=%0d",
             r, w, a, d, rdy, rd, console_valid, console_data, access_fault);
    @(posedge clk);
    model_edge(r, w, a, d, rdy);
    #1;
  endtask

  task automatic idle(input int n);
    logic [31:0] rd;
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, 32'h0, 0, rd);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    int sel;

    for (int i = 0; i < 1024; i++) ram_v[i] = 1'b0;
    rst = 1'b1; memory_write_enable = 1'b0; memory_address = 0;
    memory_write_data = 0; console_ready = 1'b0;
    repeat (2) @(posedge clk);
    model_edge(1, 0, 0, 0, 0);
    #1;

    // Reset state
    check("rst_valid", {31'b0, console_valid}, 32'h0);
    check("rst_cdata", {24'b0, console_data}, 32'h0);
    check("rst_fault", {31'b0, access_fault}, 32'h0);
    step(0, 0, 32'h8000_0004, 0, 0, rd);
    check("rst_status", rd, 32'h0000_0002);

    // RAM write/read, same-cycle old data
    step(0, 1, 32'h10, 32'h1111_1111, 0, rd);
    step(0, 1, 32'h10, 32'hDEAD_BEEF, 0, rd);
    check("ram_old", rd, 32'h1111_1111);
    step(0, 0, 32'h10, 0, 0, rd);
    check("ram_new", rd, 32'hDEAD_BEEF);
    step(0, 1, 32'hFFC, 32'h1, 0, rd);
    step(0, 0, 32'hFFC, 0, 0, rd);
    check("ram_last", rd, 32'h1);
    check("last_nofault", {31'b0, access_fault}, 32'h0);

    // Console ordering and backpressure
    step(0, 1, 32'h8000_0000, 32'h41, 0, rd);
    step(0, 1, 32'h8000_0000, 32'h42, 0, rd);
    step(0, 1, 32'h8000_0000, 32'h43, 0, rd);
    step(0, 0, 32'h8000_0004, 0, 0, rd);
    check("status_cnt3", rd, 32'h0000_0300);
    check("valid_cnt3", {31'b0, console_valid}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 32'h0, 0, 1, rd);
    end
    step(0, 0, 32'h8000_0004, 0, 0, rd);
    check("status_drained", rd, 32'h0000_0002);
    check("valid_drained", {31'b0, console_valid}, 32'h0);

    // Overflow
    for (int i = 0; i < 5; i++) step(0, 1, 32'h8000_0000, 32'h50 + i, 0, rd);
    step(0, 0, 32'h8000_0004, 0, 0, rd);
    check("status_ovf", rd, 32'h0000_0405);
    step(0, 1, 32'h8000_0000, 32'h5A, 1, rd);
    step(0, 0, 32'h8000_0004, 0, 0, rd);
    check("status_full_pushpop", rd, 32'h0000_0405);
    step(0, 1, 32'h8000_0004, 0, 0, rd);
    step(0, 0, 32'h8000_0004, 0, 0, rd);
    check("status_ovf_clr", rd, 32'h0000_0401);
    idle(0);
    for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 0, 1, rd);

    // Pointer wrap with a streaming sink
    for (int i = 0; i < 10; i++) step(0, 1, 32'h8000_0000, i, 1, rd);
    step(0, 0, 32'h0, 0, 1, rd);
    step(0, 0, 32'h8000_0004, 0, 1, rd);
    check("status_wrap", rd, 32'h0000_0002);

    // Faults
    step(0, 1, 32'h4000_0000, 32'h1234_5678, 0, rd);
    step(0, 0, 32'h10, 0, 0, rd);
    check("fault_unmapped", {31'b0, access_fault}, 32'h1);
    check("ram_untouched", rd, 32'hDEAD_BEEF);
    step(1, 0, 32'h0, 0, 0, rd);
    check("fault_rst", {31'b0, access_fault}, 32'h0);
    step(0, 0, 32'h2, 0, 0, rd);
    check("misaligned_rd", rd, 32'h0);
    step(0, 0, 32'h0, 0, 0, rd);
    check("fault_misaligned", {31'b0, access_fault}, 32'h1);

    // CYCLE counter
    step(1, 0, 32'h0, 0, 0, rd);
    idle(100);
    step(0, 0, 32'h8000_0008, 0, 0, rd);
    check("cycle_100", rd, 32'd100);
    step(1, 0, 32'h0, 0, 0, rd);
    step(0, 0, 32'h8000_0008, 0, 0, rd);
    check("cycle_after_rst", rd, 32'd0);

    // Reset mid-stream with an in-flight store
    step(0, 1, 32'h20, 32'hAAAA_5555, 0, rd);
    step(0, 1, 32'h8000_0000, 32'h61, 0, rd);
    step(0, 1, 32'h8000_0000, 32'h62, 0, rd);
    step(1, 1, 32'h20, 32'h0BAD_0BAD, 0, rd);
    step(0, 0, 32'h20, 0, 0, rd);
    check("rst_store_dropped", rd, 32'hAAAA_5555);
    check("rst_fifo_flushed", {31'b0, console_valid}, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    a = {20'h0, 4'h0, 4'($urandom_range(0, 15)), 2'b00} & 32'h0000_003C;
        2, 3:    a = 32'hFC0 + (32'($urandom_range(0, 15)) << 2);
        4:       a = 32'h8000_0000;
        5:       a = 32'h8000_0004;
        6:       a = 32'h8000_0008;
        7:       a = ($urandom_range(0, 1) != 0) ? 32'h8000_000C
                                                 : 32'h1000 + (32'($urandom_range(0, 1000)) << 2);
        8:       a = 32'h10 + 32'($urandom_range(1, 3));
        default: a = 32'h0;
      endcase
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) != 0), a, $urandom,
           ($urandom_range(0, 2) != 0), rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
